// File: rtl/disp_scan_ctrl.sv
// Four-digit seven-segment scan controller with double-buffered display word and anode-off guard.
// Outputs registered one cycle after cnt/idx state; no backpressure (load is a free-running strobe).
module disp_scan_ctrl #(
   parameter int SCAN_DIV = 50000,
   parameter int GUARD    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [15:0] data,
   input  logic [3:0]  dp,
   input  logic [3:0]  dig_en,
   output logic [3:0]  AN,
   output logic [3:0]  HEX,
   output logic        POINT,
   output logic        LE,
   output logic        frame_done
);
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);

   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  dp;
      logic [3:0]  dig_en;
   } disp_word_t;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   disp_word_t    pend_q, pend_d, act_q, act_d, load_word;
   logic          tick, frame_end, blank;
   logic [3:0]    an_q, an_d, hex_q, hex_d;
   logic          point_q, point_d, le_q, le_d, fd_q, fd_d;

   always_comb begin
      load_word.data   = data;
      load_word.dp     = dp;
      load_word.dig_en = dig_en;

      tick      = en && (cnt_q == CNT_LAST);
      frame_end = tick && (idx_q == 2'd3);

      cnt_d = cnt_q;
      idx_d = idx_q;
      if (!en) begin
         cnt_d = '0;
         idx_d = 2'd0;
      end else if (tick) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end

      // A load on the commit edge goes straight through to the active word.
      pend_d = load ? load_word : pend_q;
      act_d  = (frame_end || !en) ? pend_d : act_q;

      blank   = !en || (cnt_q < CNT_GUARD) || !act_q.dig_en[idx_q];
      hex_d   = act_q.data[{idx_q, 2'b00} +: 4];
      point_d = act_q.dp[idx_q];
      an_d    = blank ? 4'b1111 : ~(4'b0001 << idx_q);
      le_d    = blank;
      fd_d    = frame_end;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         pend_q  <= '0;
         act_q   <= '0;
         an_q    <= 4'b1111;
         hex_q   <= 4'd0;
         point_q <= 1'b0;
         le_q    <= 1'b1;
         fd_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         act_q   <= act_d;
         an_q    <= an_d;
         hex_q   <= hex_d;
         point_q <= point_d;
         le_q    <= le_d;
         fd_q    <= fd_d;
      end
   end

   assign AN         = an_q;
   assign HEX        = hex_q;
   assign POINT      = point_q;
   assign LE         = le_q;
   assign frame_done = fd_q;

endmodule
